data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the TestMIPS data port. It answers the core's load/store
//  requests: address = ALUresult, write data = WriteOnMem. Word-addressed RAM behind a
//  req/ready handshake with programmable wait states, so the core and bench can exercise stalls.
//  Also exposes a store monitor (last write, write count) for self-checking benches.
// PARAMETERS
//  DEPTH_WORDS  64  number of 32-bit words; power of two, >= 2
//  WAIT_CYCLES  2   wait states inserted before each response; 0..15
//  BASE_ADDR    0   byte address of word 0; word aligned
// PORTS
//  CLK          in   1   clock; all state changes on rising edge
//  reset        in   1   synchronous, active-high reset
//  mem_req      in   1   request valid; held high by requester until mem_ready
//  mem_we       in   1   1 = store, 0 = load; sampled with mem_req
//  mem_addr     in   32  byte address (ALUresult)
//  mem_wdata    in   32  store data (WriteOnMem)
//  mem_rdata    out  32  load data; valid only while mem_ready=1
//  mem_ready    out  1   one-cycle response strobe
//  mem_err      out  1   with mem_ready: misaligned or out-of-range access
//  last_waddr   out  32  byte address of most recent committed store
//  last_wdata   out  32  data of most recent committed store
//  wr_count     out  16  committed-store counter, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: state IDLE; mem_ready=0, mem_err=0, mem_rdata=0, last_waddr=0, last_wdata=0,
//   wr_count=0, wait counter=0. RAM contents untouched by reset.
//  FSM states: IDLE, WAIT, RESP.
//   IDLE: if mem_req=1, latch we/addr/wdata, load counter with WAIT_CYCLES.
//         Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
//   WAIT: decrement counter each cycle; on reaching 1 -> RESP. Exactly WAIT_CYCLES cycles in WAIT.
//   RESP: mem_ready=1 for exactly this cycle, then IDLE unconditionally.
//  Latency: mem_req first high in cycle c (state IDLE) -> mem_ready high in cycle c+WAIT_CYCLES+1.
//   Back-to-back: after RESP one IDLE cycle is mandatory, so the next request is accepted at c+W+2 at earliest.
//  Inputs are latched at acceptance. Later changes to addr/wdata/we while req is held are ignored.
//   Deassertion of mem_req in WAIT does not abort the transaction.
//  Error: mem_addr[1:0]!=0, or (addr-BASE_ADDR)>>2 >= DEPTH_WORDS (incl. addr<BASE_ADDR),
//   -> RESP with mem_err=1, mem_rdata=0, no RAM write, monitor unchanged.
//  Store commit: at the rising edge ending RESP. Updates RAM[idx], last_waddr, last_wdata,
//   and wr_count+1. The next accepted load returns the new data.
//  Load: mem_rdata = RAM[idx] during RESP; 0 in every other cycle.
//  Word index = (addr-BASE_ADDR)[log2(DEPTH)+1:2]; 32-bit subtract, no wrap tolerated (error check first).
//  Reset mid-operation (WAIT or RESP): transaction dropped. No RAM write and no ready pulse after reset.
//   Back in IDLE next cycle.
//  mem_err and mem_ready are never high outside RESP.
// STRUCTURE
//  Shared package mips_mem_pkg: state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2),
//   WORD_BYTES=4, MAX_WAIT=15, monitor counter width 16.
//  Sub-module mem_word_array: single-port RAM, sync write (we, idx, wdata), async read. Everything else here.
// TESTING
//  1 Reset held 3 cycles, then released -> all outputs 0, state IDLE, no ready pulse.
//  2 W=2: store addr 0x8, data 0xDEADBEEF, req in cycle c
//     -> ready only in c+3, err=0; wr_count=1, last_waddr=0x8, last_wdata=0xDEADBEEF.
//  3 Load addr 0x8 after test 2 -> mem_rdata=0xDEADBEEF with ready; rdata=0 the next cycle.
//  4 Store addr 0x6 (misaligned), then addr 0x100 with DEPTH=64
//     -> each gives ready+err, rdata=0, wr_count unchanged.
//  5 W=0: two back-to-back stores (0x0=1, 0x4=2) with req held high
//     -> ready at c+1 and c+3; wr_count=2.
//  6 Store accepted, reset asserted in WAIT -> no ready; wr_count=0; load of that addr returns old contents.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the TestMIPS data-memory responder: FSM encoding,
// word geometry, monitor width and the access-legality check.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int MAX_WAIT   = 15;
  localparam int WR_CNT_W   = 16;

  // Misaligned, below the base, or past the last word; the subtract is only
  // trusted once addr >= base has been established.
  function automatic logic access_err(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned depth);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || (addr < base) ||
           ((off >> $clog2(WORD_BYTES)) >= 32'(depth));
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port word RAM: synchronous write, asynchronous read at the same index.
module mem_word_array #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder for TestMIPS: req/ready handshake with fixed wait states,
// word RAM behind it, and a store monitor (last store, store count).
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  output logic [31:0]         mem_rdata,
  output logic                mem_ready,
  output logic                mem_err,
  output logic [31:0]         last_waddr,
  output logic [31:0]         last_wdata,
  output logic [WR_CNT_W-1:0] wr_count
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [31:0]         last_waddr_q, last_waddr_d;
  logic [31:0]         last_wdata_q, last_wdata_d;
  logic [WR_CNT_W-1:0] wr_count_q, wr_count_d;
  logic                commit;
  logic [31:0]         ram_rdata;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    last_waddr_d = last_waddr_q;
    last_wdata_d = last_wdata_q;
    wr_count_d   = wr_count_q;
    commit       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          we_d    = mem_we;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          err_d   = access_err(mem_addr, BASE_ADDR, DEPTH_WORDS);
          idx_d   = IDX_W'((mem_addr - BASE_ADDR) >> 2);
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        // Stores land on the edge that closes the response cycle.
        if (we_q && !err_q) begin
          commit       = 1'b1;
          last_waddr_d = addr_q;
          last_wdata_d = wdata_q;
          wr_count_d   = wr_count_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_waddr_q <= '0;
      last_wdata_q <= '0;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_waddr_q <= last_waddr_d;
      last_wdata_q <= last_wdata_d;
      wr_count_q   <= wr_count_d;
    end
  end

  // Request capture is only ever consumed in WAIT/RESP, so it needs no reset.
  always_ff @(posedge CLK) begin
    we_q    <= we_d;
    err_q   <= err_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    idx_q   <= idx_d;
  end

  mem_word_array #(
    .DEPTH  (DEPTH_WORDS),
    .DATA_W (32)
  ) u_ram (
    .clk   (CLK),
    .we    (commit & ~reset),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign mem_ready  = (state_q == ST_RESP);
  assign mem_err    = mem_ready & err_q;
  assign mem_rdata  = (mem_ready && !err_q && !we_q) ? ram_rdata : 32'h0;
  assign last_waddr = last_waddr_q;
  assign last_wdata = last_wdata_q;
  assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 and 0 wait states) checked
// every cycle against a transaction-level model, plus directed literal checks.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];
  logic [31:0] lwa   [2];
  logic [31:0] lwd   [2];
  logic [15:0] wcnt  [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // model state
  bit          pend   [2];
  int          due    [2];
  bit          e_err  [2];
  bit          e_load [2];
  bit          e_known[2];
  int          e_idx  [2];
  logic [31:0] e_rdata[2];
  logic [31:0] e_addr [2];
  logic [31:0] e_wdata[2];
  logic [31:0] mm     [2][64];
  bit          kn     [2][64];
  logic [31:0] m_wa   [2];
  logic [31:0] m_wd   [2];
  int          m_cnt  [2];
  // observed DUT response
  int          dut_rdy[2];
  logic [31:0] dut_rd [2];
  logic        dut_err[2];

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut0 (
    .CLK(clk), .reset(reset), .mem_req(req[0]), .mem_we(we[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_ready(ready[0]), .mem_err(err[0]),
    .last_waddr(lwa[0]), .last_wdata(lwd[0]), .wr_count(wcnt[0]));

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut1 (
    .CLK(clk), .reset(reset), .mem_req(req[1]), .mem_we(we[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_ready(ready[1]), .mem_err(err[1]),
    .last_waddr(lwa[1]), .last_wdata(lwd[1]), .wr_count(wcnt[1]));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wv(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of acceptance: response W+1 cycles later, data as of now.
  task automatic accept(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
    pend[i]    = 1'b1;
    due[i]     = cyc + wv(i) + 1;
    e_load[i]  = !w;
    e_err[i]   = (a[1:0] != 2'b00) || (a >= 32'd256);
    e_idx[i]   = int'(a[7:2]);
    e_known[i] = kn[i][e_idx[i]];
    e_rdata[i] = mm[i][e_idx[i]];
    e_addr[i]  = a;
    e_wdata[i] = d;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit rexp;
      if (ready[i] === 1'b1) begin
        dut_rdy[i] = cyc;
        dut_rd[i]  = rdata[i];
        dut_err[i] = err[i];
      end
      if (reset) begin
        pend[i]  = 1'b0;
        m_wa[i]  = 32'h0;
        m_wd[i]  = 32'h0;
        m_cnt[i] = 0;
        continue;
      end
      rexp = pend[i] && (cyc == due[i]);
      chk($sformatf("ready%0d", i), 32'(ready[i]), 32'(rexp));
      chk($sformatf("err%0d", i), 32'(err[i]), 32'(rexp && e_err[i]));
      if (!rexp || e_err[i] || (e_load[i] && e_known[i]))
        chk($sformatf("rdata%0d", i), rdata[i], (rexp && !e_err[i]) ? e_rdata[i] : 32'h0);
      chk($sformatf("last_waddr%0d", i), lwa[i], m_wa[i]);
      chk($sformatf("last_wdata%0d", i), lwd[i], m_wd[i]);
      chk($sformatf("wr_count%0d", i), 32'(wcnt[i]), 32'(m_cnt[i]));
      if (rexp) begin
        pend[i] = 1'b0;
        if (!e_load[i] && !e_err[i]) begin
          m_wa[i]  = e_addr[i];
          m_wd[i]  = e_wdata[i];
          m_cnt[i] = (m_cnt[i] + 1) & 16'hFFFF;
          mm[i][e_idx[i]] = e_wdata[i];
          kn[i][e_idx[i]] = 1'b1;
        end
      end
    end
  end

  // Issue one request from an IDLE cycle; returns in the IDLE cycle after RESP.
  task automatic txn(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input bit drop, input bit scramble);
    int target;
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    accept(i, w, a, d);
    target = due[i];
    while (cyc <= target) begin
      @(posedge clk); #1;
      if (cyc <= target) begin
        if (drop) req[i] = 1'b0;
        if (scramble) begin
          addr[i] = $urandom; wdata[i] = $urandom; we[i] = 1'($urandom);
        end
      end
    end
    req[i] = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rand_run(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = ($urandom_range(0, 63) << 2) | 32'($urandom_range(1, 3));
      else if (r == 1) a = 32'h100 + ($urandom_range(0, 1000) << 2);
      else if (r == 2) a = 32'hFFFF_FFFC;
      else             a = $urandom_range(0, 15) << 2;
      txn(i, 1'($urandom), a, $urandom, ($urandom_range(0, 3) == 0), 1'($urandom));
      tick(int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    int c;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'h0; wdata[i] = 32'h0;
      pend[i] = 1'b0; due[i] = 0; dut_rdy[i] = -1;
      m_wa[i] = 32'h0; m_wd[i] = 32'h0; m_cnt[i] = 0;
      for (int j = 0; j < 64; j++) begin mm[i][j] = 32'h0; kn[i][j] = 1'b0; end
    end
    // 1: reset for 3 cycles
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t1_ready", 32'(ready[i]), 32'h0);
      chk("t1_err", 32'(err[i]), 32'h0);
      chk("t1_rdata", rdata[i], 32'h0);
      chk("t1_waddr", lwa[i], 32'h0);
      chk("t1_wdata", lwd[i], 32'h0);
      chk("t1_count", 32'(wcnt[i]), 32'h0);
    end
    tick(2);
    chk("t1_no_ready", 32'(dut_rdy[0]), 32'hFFFF_FFFF);

    // 2: store with 2 wait states
    c = cyc;
    txn(0, 1'b1, 32'h8, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("t2_latency", 32'(dut_rdy[0]), 32'(c + 3));
    chk("t2_err", 32'(dut_err[0]), 32'h0);
    chk("t2_count", 32'(wcnt[0]), 32'd1);
    chk("t2_waddr", lwa[0], 32'h8);
    chk("t2_wdata", lwd[0], 32'hDEADBEEF);

    // 3: load back
    txn(0, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1);
    chk("t3_rdata", dut_rd[0], 32'hDEADBEEF);
    chk("t3_rdata_after", rdata[0], 32'h0);

    // 4: misaligned and out-of-range stores
    txn(0, 1'b1, 32'h6, 32'h1111_1111, 1'b0, 1'b0);
    chk("t4_mis_err", 32'(dut_err[0]), 32'h1);
    chk("t4_mis_rdata", dut_rd[0], 32'h0);
    txn(0, 1'b1, 32'h100, 32'h2222_2222, 1'b1, 1'b0);
    chk("t4_oor_err", 32'(dut_err[0]), 32'h1);
    chk("t4_oor_rdata", dut_rd[0], 32'h0);
    chk("t4_count", 32'(wcnt[0]), 32'd1);

    // 5: zero wait states, back-to-back stores with req held
    c = cyc;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0; wdata[1] = 32'd1;
    accept(1, 1'b1, 32'h0, 32'd1);
    tick(1);
    chk("t5_ready_c1", 32'(ready[1]), 32'h1);
    addr[1] = 32'h4; wdata[1] = 32'd2;
    tick(1);
    chk("t5_ready_c2", 32'(ready[1]), 32'h0);
    accept(1, 1'b1, 32'h4, 32'd2);
    tick(1);
    chk("t5_ready_c3", 32'(ready[1]), 32'h1);
    chk("t5_cycle", 32'(cyc), 32'(c + 3));
    req[1] = 1'b0;
    tick(1);
    chk("t5_count", 32'(wcnt[1]), 32'd2);
    chk("t5_wdata", lwd[1], 32'd2);

    // 6: reset during WAIT drops the store
    c = dut_rdy[0];
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'h1234_5678;
    accept(0, 1'b1, 32'h8, 32'h1234_5678);
    tick(1);
    req[0] = 1'b0; reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(4);
    chk("t6_no_ready", 32'(dut_rdy[0]), 32'(c));
    chk("t6_count", 32'(wcnt[0]), 32'h0);
    txn(0, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0);
    chk("t6_old_data", dut_rd[0], 32'hDEADBEEF);

    // randomized traffic on both instances
    fork
      rand_run(0, 150);
      rand_run(1, 200);
    join
    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
